// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
// MEM_STALL_EN adds the mem_ready handshake from memory.
interface multicycle_ctrl_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
`ifdef MEM_STALL_EN
   logic       mem_ready;
`endif
   logic [1:0] immsrc;
   logic [1:0] alusrca;
   logic [1:0] alusrcb;
   logic [2:0] alucontrol;
   logic [1:0] resultsrc;
   logic       adrsrc;
   logic       irwrite;
   logic       pcwrite;
   logic       regwrite;
   logic       memwrite;
   logic       instr_done;
   logic       illegal_op;

   modport master (
      input  op, funct3, funct7b5, zero,
`ifdef MEM_STALL_EN
      input  mem_ready,
`endif
      output immsrc, alusrca, alusrcb, alucontrol, resultsrc, adrsrc,
      output irwrite, pcwrite, regwrite, memwrite, instr_done, illegal_op
   );

   modport slave (
      output op, funct3, funct7b5, zero,
`ifdef MEM_STALL_EN
      output mem_ready,
`endif
      input  immsrc, alusrca, alusrcb, alucontrol, resultsrc, adrsrc,
      input  irwrite, pcwrite, regwrite, memwrite, instr_done, illegal_op
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore main controller for the multicycle RV32I-subset core (lw, sw, R, I, beq, jal).
// Optional MEM_STALL_EN: FETCH/MEMREAD/MEMWRITE wait on mem_ready.
module multicycle_ctrl (
   input  logic              clk,
   input  logic              reset,
   multicycle_ctrl_if.master bus
);
   localparam int unsigned STATE_W = 4;

   localparam logic [STATE_W-1:0] FETCH    = 4'd0;
   localparam logic [STATE_W-1:0] DECODE   = 4'd1;
   localparam logic [STATE_W-1:0] MEMADR   = 4'd2;
   localparam logic [STATE_W-1:0] MEMREAD  = 4'd3;
   localparam logic [STATE_W-1:0] MEMWB    = 4'd4;
   localparam logic [STATE_W-1:0] MEMWRITE = 4'd5;
   localparam logic [STATE_W-1:0] EXECUTER = 4'd6;
   localparam logic [STATE_W-1:0] EXECUTEI = 4'd7;
   localparam logic [STATE_W-1:0] ALUWB    = 4'd8;
   localparam logic [STATE_W-1:0] BEQ      = 4'd9;
   localparam logic [STATE_W-1:0] JAL      = 4'd10;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   logic [STATE_W-1:0] state, state_nx;
   logic       mem_rdy;
   logic [2:0] funct_alu;
   logic       adrsrc_c, irwrite_c, pcupdate_c, branch_c;
   logic       regwrite_c, memwrite_c, done_c, illegal_c;
   logic [1:0] alusrca_c, alusrcb_c, resultsrc_c;
   logic [2:0] alucontrol_c;

`ifdef MEM_STALL_EN
   assign mem_rdy = bus.mem_ready;
`else
   assign mem_rdy = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_nx;
   end

   // ALU operation for R/I-type; sub only for R-type with funct7b5 set
   always_comb begin
      funct_alu = ALU_ADD;
      case (bus.funct3)
         3'b000:  funct_alu = (bus.op[5] && bus.funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  funct_alu = ALU_SLT;
         3'b110:  funct_alu = ALU_OR;
         3'b111:  funct_alu = ALU_AND;
         default: funct_alu = ALU_ADD;
      endcase
   end

   always_comb begin
      state_nx     = FETCH;
      adrsrc_c     = 1'b0;
      alusrca_c    = 2'b00;
      alusrcb_c    = 2'b00;
      alucontrol_c = ALU_ADD;
      resultsrc_c  = 2'b00;
      irwrite_c    = 1'b0;
      pcupdate_c   = 1'b0;
      branch_c     = 1'b0;
      regwrite_c   = 1'b0;
      memwrite_c   = 1'b0;
      done_c       = 1'b0;
      illegal_c    = 1'b0;
      case (state)
         FETCH: begin
            alusrcb_c   = 2'b10;
            resultsrc_c = 2'b10;
            irwrite_c   = mem_rdy;
            pcupdate_c  = mem_rdy;
            state_nx    = mem_rdy ? DECODE : FETCH;
         end
         DECODE: begin
            alusrca_c = 2'b01;
            alusrcb_c = 2'b01;
            case (bus.op)
               OP_LW, OP_SW: state_nx = MEMADR;
               OP_R:         state_nx = EXECUTER;
               OP_I:         state_nx = EXECUTEI;
               OP_BEQ:       state_nx = BEQ;
               OP_JAL:       state_nx = JAL;
               default: begin
                  illegal_c = 1'b1;
                  state_nx  = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alusrca_c = 2'b10;
            alusrcb_c = 2'b01;
            state_nx  = bus.op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adrsrc_c = 1'b1;
            state_nx = mem_rdy ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            resultsrc_c = 2'b01;
            regwrite_c  = 1'b1;
            done_c      = 1'b1;
         end
         MEMWRITE: begin
            adrsrc_c   = 1'b1;
            memwrite_c = mem_rdy;
            done_c     = mem_rdy;
            state_nx   = mem_rdy ? FETCH : MEMWRITE;
         end
         EXECUTER: begin
            alusrca_c    = 2'b10;
            alucontrol_c = funct_alu;
            state_nx     = ALUWB;
         end
         EXECUTEI: begin
            alusrca_c    = 2'b10;
            alusrcb_c    = 2'b01;
            alucontrol_c = funct_alu;
            state_nx     = ALUWB;
         end
         ALUWB: begin
            regwrite_c = 1'b1;
            done_c     = 1'b1;
         end
         BEQ: begin
            alusrca_c    = 2'b10;
            alucontrol_c = ALU_SUB;
            branch_c     = 1'b1;
            done_c       = 1'b1;
         end
         JAL: begin
            alusrca_c  = 2'b01;
            alusrcb_c  = 2'b10;
            pcupdate_c = 1'b1;
            state_nx   = ALUWB;
         end
         default: state_nx = FETCH;
      endcase
   end

   // immediate format follows the opcode in every state
   always_comb begin
      case (bus.op)
         OP_SW:   bus.immsrc = 2'b01;
         OP_BEQ:  bus.immsrc = 2'b10;
         OP_JAL:  bus.immsrc = 2'b11;
         default: bus.immsrc = 2'b00;
      endcase
   end

   // reset forces every write strobe low; selects already show FETCH
   assign bus.alusrca    = alusrca_c;
   assign bus.alusrcb    = alusrcb_c;
   assign bus.alucontrol = alucontrol_c;
   assign bus.resultsrc  = resultsrc_c;
   assign bus.adrsrc     = adrsrc_c;
   assign bus.irwrite    = irwrite_c  & ~reset;
   assign bus.pcwrite    = (pcupdate_c | (branch_c & bus.zero)) & ~reset;
   assign bus.regwrite   = regwrite_c & ~reset;
   assign bus.memwrite   = memwrite_c & ~reset;
   assign bus.instr_done = done_c     & ~reset;
   assign bus.illegal_op = illegal_c  & ~reset;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors queued per instruction.
module tb_multicycle_ctrl;
   localparam int unsigned VEC_W = 18;

   localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5;
   localparam int S_XR = 6, S_XI = 7, S_AWB = 8, S_BEQ = 9, S_JAL = 10;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   typedef struct {
      string            name;
      logic [VEC_W-1:0] v;
   } sb_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;
   sb_t  sbq[$];

   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [VEC_W-1:0] actual_vec();
      return {bus.immsrc, bus.alusrca, bus.alusrcb, bus.alucontrol, bus.resultsrc,
              bus.adrsrc, bus.irwrite, bus.pcwrite, bus.regwrite, bus.memwrite,
              bus.instr_done, bus.illegal_op};
   endfunction

   // expected outputs of a controller state, from the state table
   function automatic logic [VEC_W-1:0] expv(input int s, input logic [6:0] o,
                                             input logic z, input logic [2:0] alu);
      logic [1:0] imm, sa, sb, rs;
      logic [2:0] ac;
      logic ad, ir, pw, rw, mw, dn, il;
      imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
      {sa, sb, rs, ac, ad, ir, pw, rw, mw, dn, il} = '0;
      case (s)
         S_F:   begin sb = 2'b10; rs = 2'b10; ir = 1'b1; pw = 1'b1; end
         S_D:   begin sa = 2'b01; sb = 2'b01;
                      il = !(o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL); end
         S_MA:  begin sa = 2'b10; sb = 2'b01; end
         S_MR:  ad = 1'b1;
         S_MWB: begin rs = 2'b01; rw = 1'b1; dn = 1'b1; end
         S_MW:  begin ad = 1'b1; mw = 1'b1; dn = 1'b1; end
         S_XR:  begin sa = 2'b10; ac = alu; end
         S_XI:  begin sa = 2'b10; sb = 2'b01; ac = alu; end
         S_AWB: begin rw = 1'b1; dn = 1'b1; end
         S_BEQ: begin sa = 2'b10; ac = 3'b001; pw = z; dn = 1'b1; end
         S_JAL: begin sa = 2'b01; sb = 2'b10; pw = 1'b1; end
         default: ;
      endcase
      return {imm, sa, sb, ac, rs, ad, ir, pw, rw, mw, dn, il};
   endfunction

   task automatic push(input string nm, input logic [VEC_W-1:0] v);
      sb_t e;
      e.name = nm;
      e.v    = v;
      sbq.push_back(e);
   endtask

   task automatic drain();
      sb_t e;
      while (sbq.size() > 0) begin
         @(negedge clk);
         e = sbq.pop_front();
         n_tests++;
         if (actual_vec() !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", e.name, actual_vec(), e.v);
         end
      end
   endtask

   // queue a full instruction starting at FETCH, then check it cycle by cycle
   task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic z, input logic [2:0] alu);
      int st[$];
      bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
      st.push_back(S_F);
      st.push_back(S_D);
      case (o)
         LW: begin st.push_back(S_MA); st.push_back(S_MR); st.push_back(S_MWB); end
         SW: begin st.push_back(S_MA); st.push_back(S_MW); end
         RT: begin st.push_back(S_XR); st.push_back(S_AWB); end
         IT: begin st.push_back(S_XI); st.push_back(S_AWB); end
         BQ: st.push_back(S_BEQ);
         JL: begin st.push_back(S_JAL); st.push_back(S_AWB); end
         default: ;
      endcase
      foreach (st[i]) push($sformatf("%s.c%0d", nm, i + 1), expv(st[i], o, z, alu));
      drain();
   endtask

   task automatic test_reset();
      bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
`ifdef MEM_STALL_EN
      bus.mem_ready = 1'b1;
`endif
      reset = 1'b1;
      push("reset.hold1", expv(S_F, 7'd0, 1'b0, 3'd0) & ~18'h0003F);
      push("reset.hold2", expv(S_F, 7'd0, 1'b0, 3'd0) & ~18'h0003F);
      drain();
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset_mid_sw();
      bus.op = SW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
      push("swrst.c1", expv(S_F, SW, 1'b0, 3'd0));
      push("swrst.c2", expv(S_D, SW, 1'b0, 3'd0));
      push("swrst.c3", expv(S_MA, SW, 1'b0, 3'd0));
      push("swrst.c4", expv(S_MW, SW, 1'b0, 3'd0));
      drain();
      #1 reset = 1'b1;
      #1;
      n_tests++;
      if ({bus.memwrite, bus.irwrite, bus.instr_done, bus.pcwrite} !== 4'b0000) begin
         n_fail++;
         $display("FAIL swrst.async: memwrite/irwrite/done/pcwrite got %b expected 0000",
                  {bus.memwrite, bus.irwrite, bus.instr_done, bus.pcwrite});
      end
      @(posedge clk);
      #1 reset = 1'b0;
      push("swrst.refetch", expv(S_F, SW, 1'b0, 3'd0));
      push("swrst.r2", expv(S_D, SW, 1'b0, 3'd0));
      push("swrst.r3", expv(S_MA, SW, 1'b0, 3'd0));
      push("swrst.r4", expv(S_MW, SW, 1'b0, 3'd0));
      drain();
   endtask

   task automatic test_loadstore();
      run_instr("lw", LW, 3'b010, 1'b0, 1'b0, 3'd0);
      run_instr("sw", SW, 3'b010, 1'b1, 1'b1, 3'd0);
   endtask

   task automatic test_alu();
      run_instr("r_sub",  RT, 3'b000, 1'b1, 1'b0, 3'b001);
      run_instr("i_addi", IT, 3'b000, 1'b1, 1'b0, 3'b000);
      run_instr("r_add",  RT, 3'b000, 1'b0, 1'b0, 3'b000);
      run_instr("r_and",  RT, 3'b111, 1'b0, 1'b0, 3'b010);
      run_instr("i_ori",  IT, 3'b110, 1'b0, 1'b0, 3'b011);
      run_instr("i_slti", IT, 3'b010, 1'b0, 1'b0, 3'b101);
      run_instr("r_sll",  RT, 3'b001, 1'b1, 1'b0, 3'b000);
   endtask

   task automatic test_branch();
      run_instr("beq_t", BQ, 3'b000, 1'b0, 1'b1, 3'd0);
      run_instr("beq_n", BQ, 3'b000, 1'b0, 1'b0, 3'd0);
      run_instr("jal",   JL, 3'b101, 1'b1, 1'b1, 3'd0);
   endtask

   task automatic test_illegal();
      run_instr("illegal", BAD, 3'b000, 1'b0, 1'b0, 3'd0);
      push("illegal.back", expv(S_F, BAD, 1'b0, 3'd0));
      drain();
      bus.op = IT;
      push("illegal.next", expv(S_D, IT, 1'b0, 3'd0));
      push("illegal.x",    expv(S_XI, IT, 1'b0, 3'd0));
      push("illegal.wb",   expv(S_AWB, IT, 1'b0, 3'd0));
      drain();
   endtask

   task automatic test_back_to_back();
      run_instr("b2b_lw",  LW, 3'b010, 1'b0, 1'b0, 3'd0);
      run_instr("b2b_beq", BQ, 3'b000, 1'b0, 1'b1, 3'd0);
      run_instr("b2b_sw",  SW, 3'b010, 1'b0, 1'b0, 3'd0);
   endtask

`ifdef MEM_STALL_EN
   task automatic test_stall();
      bus.op = IT; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         push($sformatf("stall.f%0d", i), expv(S_F, IT, 1'b0, 3'd0) & ~18'h00030);
      drain();
      bus.mem_ready = 1'b1;
      push("stall.go",  expv(S_F, IT, 1'b0, 3'd0));
      push("stall.dec", expv(S_D, IT, 1'b0, 3'd0));
      push("stall.x",   expv(S_XI, IT, 1'b0, 3'd0));
      push("stall.wb",  expv(S_AWB, IT, 1'b0, 3'd0));
      drain();
   endtask
`endif

   initial begin
      test_reset();
      test_loadstore();
      test_alu();
      test_branch();
      test_illegal();
      test_back_to_back();
      test_reset_mid_sw();
`ifdef MEM_STALL_EN
      test_stall();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style main controller for the multicycle RV32I-subset core.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives the immediate-extend select `immsrc`, ALU operand/op selects, result mux and all architectural write enables.
- Sits beside the datapath: takes the opcode/funct fields from the instruction register plus the ALU `zero` flag.

Parameters:
- None. Opcode set is fixed: lw, sw, R-type, I-type ALU, beq, jal.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU result == 0
- immsrc  out  2  extend select: 00 I, 01 S, 10 B, 11 J
- alusrca  out  2  00 PC, 01 OldPC, 10 RegA
- alusrcb  out  2  00 RegB, 01 ImmExt, 10 const 4
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- adrsrc  out  1  0 PC, 1 Result
- irwrite  out  1  instruction register enable
- pcwrite  out  1  PC enable
- regwrite  out  1  register file write enable
- memwrite  out  1  data memory write enable
- instr_done  out  1  1-cycle pulse in the last state of each instruction
- illegal_op  out  1  1-cycle pulse in DECODE when op is unsupported

Behaviour:
- Reset and state register
  - 4-bit state register, asynchronously reset to FETCH.
  - While reset is high: irwrite, pcwrite, regwrite, memwrite, instr_done and illegal_op are forced to 0. Selects take their FETCH values (adrsrc=0, alusrca=00, alusrcb=10, alucontrol=000, resultsrc=10).
  - Reset released mid-instruction: restart at FETCH with no partial write.
- immsrc is combinational from op in every state:
  - sw → 01, beq → 10, jal → 11, all others (incl. illegal) → 00.
- States and Moore outputs (unlisted enables 0; unlisted selects don't-care, driven 0):
  - FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=add, resultsrc=10, pcupdate=1. Next: DECODE.
  - DECODE: alusrca=01, alusrcb=01, aluop=add (branch target).
    - Next by op: 0000011/0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL.
    - Any other op → illegal_op=1, next FETCH.
  - MEMADR: alusrca=10, alusrcb=01, aluop=add. Next: lw → MEMREAD, sw → MEMWRITE.
  - MEMREAD: resultsrc=00, adrsrc=1. Next: MEMWB.
  - MEMWB: resultsrc=01, regwrite=1, instr_done=1. Next: FETCH.
  - MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1, instr_done=1. Next: FETCH.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=funct. Next: ALUWB.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=funct. Next: ALUWB.
  - ALUWB: resultsrc=00, regwrite=1, instr_done=1. Next: FETCH.
  - BEQ: alusrca=10, alusrcb=00, aluop=sub, resultsrc=00, branch=1, instr_done=1. Next: FETCH.
  - JAL: alusrca=01, alusrcb=10, aluop=add, resultsrc=00, pcupdate=1. Next: ALUWB.
  - Unused encodings: next FETCH, all enables 0.
- ALU decode
  - aluop=funct, decoded from funct3:
    - 000: sub only when op[5]=1 and funct7b5=1, else add.
    - 010 → slt; 110 → or; 111 → and.
    - other funct3 → add.
- pcwrite = pcupdate | (branch & zero), sampled in the same cycle.
- Cycle counts, FETCH to FETCH inclusive of FETCH: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.

Optional Feature:
- Macro MEM_STALL_EN.
- Defined:
  - Adds input `mem_ready` (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold state while mem_ready=0.
  - irwrite, pcwrite and memwrite assert only in the cycle where mem_ready=1, so each write fires exactly once per instruction.
- Undefined: no port; memory is treated as always ready.

Test Plan:
- Reset asserted mid-MEMWRITE (sw) → memwrite drops to 0 asynchronously; after release the FSM is in FETCH with irwrite=1.
- lw (op=0000011) → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regwrite=1 and resultsrc=01 only in MEMWB; instr_done at cycle 5; immsrc=00 throughout.
- R-type sub (funct3=000, funct7b5=1) → alucontrol=001 in EXECUTER, then regwrite in ALUWB. Same fields with op=0010011 (addi) → alucontrol=000.
- beq with zero=1 → pcwrite=1 in BEQ; with zero=0 → pcwrite=0. 3 cycles each; immsrc=10.
- jal (op=1101111) → immsrc=11; JAL state has pcwrite=1, alusrca=01, alusrcb=10; then regwrite in ALUWB.
- op=1111111 → illegal_op pulse in DECODE, no write enables, back in FETCH on the next cycle. With MEM_STALL_EN, mem_ready=0 for 3 cycles in FETCH → irwrite is 0 for those 3 cycles, then pulses exactly once.
